// File: rtl/mem4k_dp_pkg.sv
// Shared memory-bus constants for the 4 KiB dual-port RAM and its clients.
package mem4k_dp_pkg;

  localparam int unsigned MM_ADDR_W = 12;
  localparam int unsigned MM_DATA_W = 32;
  localparam int unsigned MM_WORDS  = 1 << (MM_ADDR_W - 2);
  localparam int unsigned MM_IDX_W  = MM_ADDR_W - 2;

  localparam logic MM_ENB_W = 1'b1;
  localparam logic MM_ENB_R = 1'b0;

  localparam logic [1:0] MM_SIZE_B = 2'b00;
  localparam logic [1:0] MM_SIZE_H = 2'b01;
  localparam logic [1:0] MM_SIZE_W = 2'b10;

  // Word index of a byte address; bits above MM_ADDR_W alias.
  function automatic logic [MM_IDX_W-1:0] word_idx(input logic [MM_DATA_W-1:0] addr);
    return addr[MM_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/mem4k_dp_if.sv
// Two-port memory bus: port A word fetch/load, port B sized data access.
interface mem4k_dp_if;

  logic        A_EnWR;
  logic [31:0] A_ABus;
  logic [31:0] A_DBusW;
  logic [31:0] A_DBusR;

  logic        B_EnWR;
  logic [1:0]  B_Size;
  logic [31:0] B_ABus;
  logic [31:0] B_DBusW;
  logic [31:0] B_DBusR;

  modport master (
    output A_EnWR, A_ABus, A_DBusW,
    input  A_DBusR,
    output B_EnWR, B_Size, B_ABus, B_DBusW,
    input  B_DBusR
  );

  modport slave (
    input  A_EnWR, A_ABus, A_DBusW,
    output A_DBusR,
    input  B_EnWR, B_Size, B_ABus, B_DBusW,
    output B_DBusR
  );

endinterface

// File: rtl/mem4k_dp_mem_lane_align.sv
// Byte-lane steering for port B: write byte-enables/replicated data and
// right-aligned, zero-extended read extraction.
module mem_lane_align
  import mem4k_dp_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword_i[7:0];
    unique case (offset_i)
      2'd0: byte_sel = rword_i[7:0];
      2'd1: byte_sel = rword_i[15:8];
      2'd2: byte_sel = rword_i[23:16];
      2'd3: byte_sel = rword_i[31:24];
      default: byte_sel = rword_i[7:0];
    endcase
    half_sel = offset_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  // Write data is replicated across lanes so the enables alone pick the target bytes.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rword_i;
    case (size_i)
      MM_SIZE_B: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, byte_sel};
      end
      MM_SIZE_H: begin
        be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, half_sel};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
    endcase
  end

endmodule

// File: rtl/mem4k_dp.sv
// 4 KiB true dual-port RAM: four 1024x8 lane arrays, read-first, port B wins
// same-byte write collisions; reset clears only the read registers.
module mem4k_dp
  import mem4k_dp_pkg::*;
(
  input  logic     clk_base,
  input  logic     rst,
  mem4k_dp_if.slave mem_io
);

  logic [MM_IDX_W-1:0] a_idx, b_idx;
  logic                a_we, b_we;
  logic [31:0]         a_rword, b_rword;
  logic [31:0]         b_wdata_lane, b_rdata;
  logic [3:0]          b_be;
  logic [31:0]         a_rdata_d, a_rdata_q;
  logic [31:0]         b_rdata_d, b_rdata_q;

  assign a_idx = word_idx(mem_io.A_ABus);
  assign b_idx = word_idx(mem_io.B_ABus);
  assign a_we  = (mem_io.A_EnWR == MM_ENB_W);
  assign b_we  = (mem_io.B_EnWR == MM_ENB_W);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_io.A_ABus[31:MM_ADDR_W], mem_io.A_ABus[1:0],
                              mem_io.B_ABus[31:MM_ADDR_W]};

  mem_lane_align u_align (
    .size_i   (mem_io.B_Size),
    .offset_i (mem_io.B_ABus[1:0]),
    .wdata_i  (mem_io.B_DBusW),
    .rword_i  (b_rword),
    .be_o     (b_be),
    .wdata_o  (b_wdata_lane),
    .rdata_o  (b_rdata)
  );

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] lane_q [MM_WORDS];

    // B is assigned last so it wins when both ports hit the same byte.
    always_ff @(posedge clk_base) begin
      if (a_we) lane_q[a_idx] <= mem_io.A_DBusW[8*l +: 8];
      if (b_we && b_be[l]) lane_q[b_idx] <= b_wdata_lane[8*l +: 8];
    end

    assign a_rword[8*l +: 8] = lane_q[a_idx];
    assign b_rword[8*l +: 8] = lane_q[b_idx];
  end

  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (rst) begin
      a_rdata_d = '0;
      b_rdata_d = '0;
    end else begin
      if (!a_we) a_rdata_d = a_rword;
      if (!b_we) b_rdata_d = b_rdata;
    end
  end

  always_ff @(posedge clk_base) begin
    a_rdata_q <= a_rdata_d;
    b_rdata_q <= b_rdata_d;
  end

  assign mem_io.A_DBusR = a_rdata_q;
  assign mem_io.B_DBusR = b_rdata_q;

endmodule

// File: tb/tb_mem4k_dp.sv
// Bench for mem4k_dp: directed vector table, a hold sequence, then random
// traffic against a byte-array reference model.
module tb_mem4k_dp;

  logic clk_base = 1'b0;
  logic rst;

  mem4k_dp_if bus ();

  mem4k_dp dut (
    .clk_base (clk_base),
    .rst      (rst),
    .mem_io   (bus)
  );

  always #5 clk_base = ~clk_base;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0]  ref_mem [4096];
  logic [31:0] m_a = 32'h0;
  logic [31:0] m_b = 32'h0;

  typedef struct {
    logic        r;
    logic        aw;
    logic [31:0] aa;
    logic [31:0] ad;
    logic        bw;
    logic [1:0]  bs;
    logic [31:0] ba;
    logic [31:0] bd;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t v(input logic r, input logic aw, input logic [31:0] aa,
                             input logic [31:0] ad, input logic bw, input logic [1:0] bs,
                             input logic [31:0] ba, input logic [31:0] bd,
                             input logic [31:0] ea, input logic [31:0] eb);
    vec_t t;
    t.r = r; t.aw = aw; t.aa = aa; t.ad = ad;
    t.bw = bw; t.bs = bs; t.ba = ba; t.bd = bd;
    t.ea = ea; t.eb = eb;
    return t;
  endfunction

  function automatic logic [31:0] ref_word(input int base);
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clk_base cycle: model reads old contents, then applies A then B writes.
  task automatic cyc(input logic r, input logic aw, input logic [31:0] aa,
                     input logic [31:0] ad, input logic bw, input logic [1:0] bs,
                     input logic [31:0] ba, input logic [31:0] bd);
    int ab, bb, bh, bwd;
    rst         = r;
    bus.A_EnWR  = aw;
    bus.A_ABus  = aa;
    bus.A_DBusW = ad;
    bus.B_EnWR  = bw;
    bus.B_Size  = bs;
    bus.B_ABus  = ba;
    bus.B_DBusW = bd;
    ab  = int'(aa % 32'd4096);
    ab  = ab - ab % 4;
    bb  = int'(ba % 32'd4096);
    bh  = bb - bb % 2;
    bwd = bb - bb % 4;
    if (r) begin
      m_a = 32'h0;
      m_b = 32'h0;
    end else begin
      if (!aw) m_a = ref_word(ab);
      if (!bw) begin
        if (bs == 2'b00)      m_b = 32'(ref_mem[bb]);
        else if (bs == 2'b01) m_b = 32'(ref_mem[bh]) + 32'(ref_mem[bh+1]) * 256;
        else                  m_b = ref_word(bwd);
      end
    end
    if (aw) for (int i = 0; i < 4; i++) ref_mem[ab+i] = ad[8*i +: 8];
    if (bw) begin
      if (bs == 2'b00) ref_mem[bb] = bd[7:0];
      else if (bs == 2'b01) begin
        ref_mem[bh]   = bd[7:0];
        ref_mem[bh+1] = bd[15:8];
      end else for (int i = 0; i < 4; i++) ref_mem[bwd+i] = bd[8*i +: 8];
    end
    @(posedge clk_base);
    #1;
  endtask

  initial begin
    // Columns: rst, A we/addr/data, B we/size/addr/data, expected A_DBusR, B_DBusR.
    tbl[0]  = v(1, 1, 32'h800,  32'h00500093, 0, 2'b10, 32'h0,   32'h0, 32'h0, 32'h0);
    tbl[1]  = v(1, 1, 32'h804,  32'h00A00113, 0, 2'b10, 32'h0,   32'h0, 32'h0, 32'h0);
    tbl[2]  = v(0, 0, 32'h800,  32'h0, 1, 2'b10, 32'h100, 32'hDEADBEEF, 32'h00500093, 32'h0);
    tbl[3]  = v(0, 0, 32'h804,  32'h0, 0, 2'b00, 32'h101, 32'h0, 32'h00A00113, 32'h000000BE);
    tbl[4]  = v(0, 0, 32'h804,  32'h0, 0, 2'b01, 32'h102, 32'h0, 32'h00A00113, 32'h0000DEAD);
    tbl[5]  = v(0, 1, 32'h1000, 32'h11111111, 1, 2'b00, 32'h103, 32'h55,
                32'h00A00113, 32'h0000DEAD);
    tbl[6]  = v(0, 0, 32'h0,    32'h0, 0, 2'b10, 32'h100, 32'h0, 32'h11111111, 32'h55ADBEEF);
    tbl[7]  = v(0, 0, 32'h0,    32'h0, 1, 2'b01, 32'h100, 32'h1234, 32'h11111111, 32'h55ADBEEF);
    tbl[8]  = v(0, 0, 32'h800,  32'h0, 0, 2'b10, 32'h100, 32'h0, 32'h00500093, 32'h55AD1234);
    tbl[9]  = v(0, 1, 32'h200,  32'hAAAAAAAA, 1, 2'b00, 32'h200, 32'hBB,
                32'h00500093, 32'h55AD1234);
    tbl[10] = v(0, 0, 32'h200,  32'h0, 0, 2'b10, 32'h200, 32'h0, 32'hAAAAAABB, 32'hAAAAAABB);
    tbl[11] = v(0, 1, 32'h300,  32'h01020304, 0, 2'b10, 32'h100, 32'h0,
                32'hAAAAAABB, 32'h55AD1234);
    tbl[12] = v(0, 1, 32'h300,  32'hCAFEF00D, 0, 2'b10, 32'h300, 32'h0,
                32'hAAAAAABB, 32'h01020304);
    tbl[13] = v(0, 0, 32'h300,  32'h0, 0, 2'b00, 32'h303, 32'h0, 32'hCAFEF00D, 32'h000000CA);
    tbl[14] = v(0, 0, 32'h300,  32'h0, 1, 2'b10, 32'h300, 32'h0BADCAFE,
                32'hCAFEF00D, 32'h000000CA);
    tbl[15] = v(0, 0, 32'h300,  32'h0, 0, 2'b01, 32'h302, 32'h0, 32'h0BADCAFE, 32'h00000BAD);
    tbl[16] = v(0, 0, 32'h804,  32'h0, 0, 2'b11, 32'h303, 32'h0, 32'h00A00113, 32'h0BADCAFE);
    tbl[17] = v(1, 0, 32'h800,  32'h0, 0, 2'b10, 32'h100, 32'h0, 32'h0, 32'h0);
    tbl[18] = v(1, 1, 32'h400,  32'h77777777, 0, 2'b10, 32'h100, 32'h0, 32'h0, 32'h0);
    tbl[19] = v(0, 0, 32'h400,  32'h0, 0, 2'b10, 32'h100, 32'h0, 32'h77777777, 32'h55AD1234);
    tbl[20] = v(0, 0, 32'h200,  32'h0, 0, 2'b00, 32'h102, 32'h0, 32'hAAAAAABB, 32'h000000AD);

    // Preload every word through port A under reset so the model is fully defined.
    for (int i = 0; i < 1024; i++) cyc(1, 1, 32'(i * 4), $urandom, 0, 2'b10, 32'h0, 32'h0);
    check("reset_a", bus.A_DBusR, 32'h0);
    check("reset_b", bus.B_DBusR, 32'h0);

    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].r, tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].bw, tbl[i].bs, tbl[i].ba, tbl[i].bd);
      check($sformatf("vec%0d_a", i), bus.A_DBusR, tbl[i].ea);
      check($sformatf("vec%0d_b", i), bus.B_DBusR, tbl[i].eb);
    end

    // Outputs must hold across consecutive write cycles on the same port.
    cyc(0, 0, 32'h800, 32'h0, 0, 2'b00, 32'h303, 32'h0);
    check("hold_rd_a", bus.A_DBusR, 32'h00500093);
    check("hold_rd_b", bus.B_DBusR, 32'h0000000B);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'h900 + 32'(i * 4), 32'h5A5A0000 + 32'(i), 1, 2'b10, 32'hA00 + 32'(i * 4),
          32'h0);
      check($sformatf("hold%0d_a", i), bus.A_DBusR, 32'h00500093);
      check($sformatf("hold%0d_b", i), bus.B_DBusR, 32'h0000000B);
    end
    cyc(0, 0, 32'h908, 32'h0, 0, 2'b01, 32'h902, 32'h0);
    check("hold_after_a", bus.A_DBusR, 32'h5A5A0002);
    check("hold_after_b", bus.B_DBusR, 32'h00005A5A);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      // Bias some cycles onto the same word to exercise collisions.
      if ($urandom_range(0, 3) == 0) rb = {ra[31:2], 2'(rb)};
      cyc(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), ra, $urandom,
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rb, $urandom);
      check("rand_a", bus.A_DBusR, m_a);
      check("rand_b", bus.B_DBusR, m_b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
